// File: rtl/packet_fifo.sv
// Packet FIFO: words are written with in_shift/in_end and only become readable once their packet commits.
// Latency: a commit on edge N shows the first word on out_* after edge N+1; a pop shows the next word right after its edge.
// Backpressure: registered in_full hint, asserted when free entries < FULL_MARGIN; shifts into a full store drop the word.
//
// Optional feature macro: PACKET_FIFO_ABORT_EN (in_abort, overflow rollback, drop counter).
// Ports:
//   clk, rst                     single clock, synchronous active-high reset
//   in_full                      almost-full hint (registered from last cycle's occupancy)
//   in_shift, in_data, in_end    write word; in_end marks the last word and commits the packet
//   in_abort                     discard the open packet (only with PACKET_FIFO_ABORT_EN)
//   out_pop                      consume head word
//   out_nempty, out_data         head word valid / head word
//   out_length, out_start        packet length (valid on first word) / head is first word
//   out_end                      head is last word
//   out_packets                  committed packets not fully popped
//   drop_count                   packets rolled back on overflow, saturating
module packet_fifo #(
  parameter int DATA_BITS   = 8,
  parameter int DEPTH       = 64,
  parameter int LENGTH_BITS = 8,
  parameter int MAX_LENGTH  = 60,
  parameter int FULL_MARGIN = 3,
  parameter int COUNT_BITS  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   in_full,
  input  logic                   in_shift,
  input  logic [DATA_BITS-1:0]   in_data,
  input  logic                   in_end,
  input  logic                   in_abort,
  input  logic                   out_pop,
  output logic                   out_nempty,
  output logic [DATA_BITS-1:0]   out_data,
  output logic [LENGTH_BITS-1:0] out_length,
  output logic                   out_start,
  output logic                   out_end,
  output logic [$clog2(DEPTH):0] out_packets,
  output logic [COUNT_BITS-1:0]  drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  typedef logic [PW-1:0] ptr_t;

  localparam ptr_t                   PTR_ONE   = ptr_t'(1);
  localparam ptr_t                   PTR_DEPTH = ptr_t'(DEPTH);
  localparam ptr_t                   PTR_MARG  = ptr_t'(FULL_MARGIN);
  localparam logic [LENGTH_BITS-1:0] LEN_ONE   = LENGTH_BITS'(1);
  localparam logic [LENGTH_BITS-1:0] LEN_MAX   = LENGTH_BITS'(MAX_LENGTH);

  logic [DATA_BITS-1:0]   data_mem [DEPTH];
  logic [LENGTH_BITS-1:0] len_mem  [DEPTH];
  logic [DEPTH-1:0]       start_mem;
  logic [DEPTH-1:0]       end_mem;

  ptr_t wr, wr_start, commit, rd, rd_next, occupancy, wr_last;
  logic [LENGTH_BITS-1:0] len;
  logic space, pop;
  logic abort_now, store, commit_ev, rollback, do_commit, do_drop_commit;

  assign occupancy = wr - rd;
  assign space     = (occupancy != PTR_DEPTH);
  assign wr_last   = wr - PTR_ONE;
  assign pop       = out_pop && out_nempty;
  assign rd_next   = rd + ptr_t'(pop);

`ifdef PACKET_FIFO_ABORT_EN
  logic ovf;
`else
  logic abort_unused;
  assign abort_unused = in_abort;
`endif

  always_comb begin
    abort_now      = 1'b0;
    rollback       = 1'b0;
    do_commit      = 1'b0;
    do_drop_commit = 1'b0;
`ifdef PACKET_FIFO_ABORT_EN
    abort_now      = in_abort;
`endif
    store     = in_shift && space && !abort_now;
    commit_ev = in_shift && !abort_now && (in_end || len == LEN_MAX);
`ifdef PACKET_FIFO_ABORT_EN
    // A packet that lost any word (earlier or right now) is thrown away at its commit point.
    rollback  = commit_ev && (ovf || !space);
    do_commit = commit_ev && !rollback;
`else
    do_commit = commit_ev && space;
    // The committing word itself was dropped: close the packet on the last stored word, if any.
    do_drop_commit = commit_ev && !space && (wr != wr_start);
`endif
  end

  // Write-side pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr       <= '0;
      wr_start <= '0;
      commit   <= '0;
      len      <= LEN_ONE;
    end else if (abort_now || rollback) begin
      wr  <= wr_start;
      len <= LEN_ONE;
    end else if (do_commit) begin
      wr       <= wr + PTR_ONE;
      wr_start <= wr + PTR_ONE;
      commit   <= wr + PTR_ONE;
      len      <= LEN_ONE;
    end else if (do_drop_commit) begin
      wr_start <= wr;
      commit   <= wr;
      len      <= LEN_ONE;
    end else if (store) begin
      wr  <= wr + PTR_ONE;
      len <= len + LEN_ONE;
    end
  end

`ifdef PACKET_FIFO_ABORT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf        <= 1'b0;
      drop_count <= '0;
    end else begin
      if (abort_now || rollback) ovf <= 1'b0;
      else if (in_shift && !space) ovf <= 1'b1;
      if (rollback && drop_count != '1) drop_count <= drop_count + COUNT_BITS'(1);
    end
  end
`else
  assign drop_count = '0;
`endif

  // Storage; entries beyond wr are free, so writes during rollback are harmless.
  always_ff @(posedge clk) begin
    if (store) begin
      data_mem[wr[AW-1:0]]  <= in_data;
      start_mem[wr[AW-1:0]] <= (wr == wr_start);
      end_mem[wr[AW-1:0]]   <= commit_ev;
    end
    if (do_commit) len_mem[wr_start[AW-1:0]] <= len;
    if (do_drop_commit) begin
      end_mem[wr_last[AW-1:0]]  <= 1'b1;
      len_mem[wr_start[AW-1:0]] <= len - LEN_ONE;
    end
  end

  // Read side: registered view of the entry at the post-pop head, so pops never leave a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd          <= '0;
      out_nempty  <= 1'b0;
      out_data    <= '0;
      out_length  <= '0;
      out_start   <= 1'b0;
      out_end     <= 1'b0;
      out_packets <= '0;
      in_full     <= 1'b0;
    end else begin
      rd         <= rd_next;
      out_nempty <= (rd_next != commit);
      out_data   <= data_mem[rd_next[AW-1:0]];
      out_length <= len_mem[rd_next[AW-1:0]];
      out_start  <= start_mem[rd_next[AW-1:0]];
      out_end    <= end_mem[rd_next[AW-1:0]];
      in_full    <= ((PTR_DEPTH - occupancy) < PTR_MARG);
      case ({do_commit || do_drop_commit, pop && out_end})
        2'b10:   out_packets <= out_packets + PTR_ONE;
        2'b01:   out_packets <= out_packets - PTR_ONE;
        default: out_packets <= out_packets;
      endcase
    end
  end

endmodule
